cordic_ppl_param: RTL and testbench
===================================

// Module: cordic_ppl_param
// PURPOSE
//  Parametrised pipelined CORDIC rotator. Computes cos and sin of a signed fixed-point angle over the full range [-pi, pi].
//  Iteration count, word length and iterations-per-stage are elaboration-time choices.
//  Carries a valid/tag sideband through the pipe with clk_en stall support.
//  Sits between the floating_to_fixed and fixed_to_float units inside the cosine custom-instruction wrapper.
// PARAMETERS
//  WL             22  data word length, signed two's complement
//  FRAC           19  fractional bits; format Q(WL-FRAC).FRAC, and WL-FRAC >= 3 so that +-pi fits
//  N_ITER         16  total CORDIC micro-rotations; N_ITER <= FRAC and N_ITER <= 32
//  ITER_PER_STAGE  8  micro-rotations per register stage; N_ITER % ITER_PER_STAGE == 0
//  TAG_W           4  sideband tag width (>=1)
// PORTS
//  clock      in   1      rising-edge clock
//  aclr_n     in   1      asynchronous active-low reset
//  clk_en     in   1      global advance; when low, every register holds its value
//  in_valid   in   1      in_angle and in_tag are valid this cycle
//  in_angle   in   WL     angle in radians, Q(WL-FRAC).FRAC
//  in_tag     in   TAG_W  opaque tag returned alongside the result
//  out_valid  out  1      out_cos, out_sin, out_tag and out_ovf are valid
//  out_cos    out  WL     cos(angle), Q(WL-FRAC).FRAC
//  out_sin    out  WL     sin(angle), Q(WL-FRAC).FRAC
//  out_tag    out  TAG_W  tag of the returned result
//  out_ovf    out  1      input lay outside [-PI, PI] and was clamped
// BEHAVIOUR
//  - Reset: aclr_n low clears all registers asynchronously. All outputs read 0.
//  - NSTAGE = N_ITER/ITER_PER_STAGE. Latency = 1+NSTAGE clk_en-qualified cycles (3 at defaults).
//  - Throughput: one operation per enabled cycle; no backpressure.
//  - Valid/tag chain: shifts on every clk_en cycle regardless of in_valid, so a bubble stays a bubble.
//  - Data registers: load only when clk_en and the stage's incoming valid are both high; otherwise they hold.
//  - Outputs hold the last result while out_valid is low.
//  - clk_en low: the entire pipe freezes, including the valid chain. No operation is lost or duplicated.
//  - Input stage (register 0), applied to angle a:
//    - a > PI or a < -PI: clamp a to +-PI and set the ovf bit.
//    - a > PI_2: z = a - PI, neg = 1.
//    - a < -PI_2: z = a + PI, neg = 1.
//    - Otherwise: z = a, neg = 0.
//    - Load x = K, y = 0. The values a = +-PI_2 exactly are handled unrotated (neg = 0).
//  - Micro-rotation i (i = 0..N_ITER-1):
//    - d = (z >= 0) ? +1 : -1
//    - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i]
//    - Shifts are arithmetic (truncating); add/sub wraps at WL bits; no saturation.
//  - Stage s (s = 0..NSTAGE-1): performs iterations s*ITER_PER_STAGE .. (s+1)*ITER_PER_STAGE-1 combinationally, then registers.
//  - Final register: out_cos = neg ? -x : x; out_sin = neg ? -y : y (two's-complement negate).
//  - neg and ovf travel with their operation through every stage.
//  - Illegal parameter combinations (divisibility, N_ITER > FRAC, WL-FRAC < 3) must stop elaboration (generate-time $error).
// STRUCTURE
//  - Header cordic_pkg.vh holds:
//    - ATAN_Q32[0:31]: atan(2^-i), Q0.32
//    - K_Q32: 0.6072529350, Q0.32
//    - PI_Q32, PI_2_Q32
//    - Function cordic_q(val_q32, FRAC): reduces a Q32 constant to FRAC bits, round-half-up
//  - Sub-module cordic_stage #(WL, FRAC, FIRST_ITER, COUNT):
//    - COUNT combinational micro-rotations, then a clk_en/valid-gated register carrying x, y, z, neg, ovf, tag and valid
//    - Instantiated NSTAGE times in a generate loop
//    - Subsumes per-iteration cordic_rot_param instances
//  - Top: input range-reduction register, stage chain, output negate register.
// TESTING (defaults; 1.0 = 0x80000; accuracy tolerance +-48 LSB vs real cos/sin)
//  1. Reset, then a=0 (valid, tag 3) -> 3 cycles later out_valid=1; cos~0x80000, sin~0; tag=3; ovf=0.
//  2. Back-to-back a = pi/6, 2pi/3, -3pi/4, -pi/2 -> four consecutive valid results in order.
//     Expected cos/sin: (0x6ED9F, 0x40000), (-0x40000, 0x6ED9F), (-0x5A827, -0x5A827), (~0, -0x80000).
//  3. Pattern v,0,v with clk_en low 2 cycles mid-flight -> bubble preserved; results delayed exactly 2 cycles; values unchanged.
//  4. a = 0x1E0000 (3.75) and its negation -> clamped; cos~-0x80000, sin~0; ovf=1.
//  5. aclr_n pulsed low while 2 ops are in flight -> out_valid and all outputs 0 immediately.
//     No stale result appears after release; the next op completes normally.
//  6. Re-elaborate WL=24, FRAC=20, N_ITER=20, ITER_PER_STAGE=4 -> latency 6; a = pi/3 gives cos~0x80000, sin~0xDDB3D (+-16 LSB).

Source files
------------

// File: rtl/cordic_ppl_param_pkg.sv
// Shared CORDIC constants in Q0.32 and the helper that reduces them to a FRAC-bit fraction.
package cordic_ppl_param_pkg;

  // 0.6072529350 (gain compensation), pi and pi/2, all scaled by 2^32
  localparam logic [63:0] K_Q32    = 64'h0000_0000_9B74_EDA8;
  localparam logic [63:0] PI_Q32   = 64'h0000_0003_243F_6A89;
  localparam logic [63:0] PI_2_Q32 = 64'h0000_0001_921F_B544;

  // atan(2^-i) scaled by 2^32; beyond i=10 it equals 2^-i to within half an LSB
  function automatic logic [63:0] atan_q32(input int unsigned i);
    case (i)
      0:       return 64'hC90F_DAA2;
      1:       return 64'h76B1_9C16;
      2:       return 64'h3EB6_EBF2;
      3:       return 64'h1FD5_BA9B;
      4:       return 64'h0FFA_ADDC;
      5:       return 64'h07FF_556F;
      6:       return 64'h03FF_EAAB;
      7:       return 64'h01FF_FD55;
      8:       return 64'h00FF_FFAB;
      9:       return 64'h007F_FFF5;
      10:      return 64'h003F_FFFF;
      default: return 64'd1 << (32 - i);
    endcase
  endfunction

  // Q0.32 -> FRAC fractional bits, rounding half up
  function automatic logic [63:0] cordic_q(input logic [63:0] val_q32, input int unsigned frac);
    if (frac >= 32) begin
      return val_q32 << (frac - 32);
    end
    return (val_q32 + (64'd1 << (31 - frac))) >> (32 - frac);
  endfunction

endpackage

// File: rtl/cordic_ppl_param_stage.sv
// One pipeline stage: COUNT unrolled micro-rotations followed by a clk_en/valid-gated register.
// The last stage of the chain also applies the quadrant-correcting negate before registering.
module cordic_ppl_param_stage
  import cordic_ppl_param_pkg::*;
#(
  parameter int unsigned WL         = 22,
  parameter int unsigned FRAC       = 19,
  parameter int unsigned FIRST_ITER = 0,
  parameter int unsigned COUNT      = 8,
  parameter int unsigned TAG_W      = 4,
  parameter bit          NEG_OUT    = 1'b0
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 clk_en_i,
  input  logic                 valid_i,
  input  logic signed [WL-1:0] x_i,
  input  logic signed [WL-1:0] y_i,
  input  logic signed [WL-1:0] z_i,
  input  logic                 neg_i,
  input  logic                 ovf_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 valid_o,
  output logic signed [WL-1:0] x_o,
  output logic signed [WL-1:0] y_o,
  output logic signed [WL-1:0] z_o,
  output logic                 neg_o,
  output logic                 ovf_o,
  output logic [TAG_W-1:0]     tag_o
);

  function automatic logic [WL-1:0] atan_c(input int unsigned i);
    logic [63:0] full;
    full = cordic_q(atan_q32(i), FRAC);
    return full[WL-1:0];
  endfunction

  logic signed [WL-1:0] x_d, y_d, z_d, x_sh, y_sh;
  logic signed [WL-1:0] x_r, y_r;

  // Unrolled micro-rotations; d = +1 while the residual angle is non-negative
  always_comb begin
    x_d  = x_i;
    y_d  = y_i;
    z_d  = z_i;
    x_sh = '0;
    y_sh = '0;
    for (int unsigned k = 0; k < COUNT; k++) begin
      x_sh = x_d >>> (FIRST_ITER + k);
      y_sh = y_d >>> (FIRST_ITER + k);
      if (z_d[WL-1]) begin
        x_d = x_d + y_sh;
        y_d = y_d - x_sh;
        z_d = z_d + atan_c(FIRST_ITER + k);
      end else begin
        x_d = x_d - y_sh;
        y_d = y_d + x_sh;
        z_d = z_d - atan_c(FIRST_ITER + k);
      end
    end
  end

  // Undo the +-pi fold from the input stage (final stage only)
  always_comb begin
    x_r = x_d;
    y_r = y_d;
    if (NEG_OUT && neg_i) begin
      x_r = -x_d;
      y_r = -y_d;
    end
  end

  // Valid shifts on every enabled cycle; the operation's data only moves with it
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      valid_o <= 1'b0;
      x_o     <= '0;
      y_o     <= '0;
      z_o     <= '0;
      neg_o   <= 1'b0;
      ovf_o   <= 1'b0;
      tag_o   <= '0;
    end else if (clk_en_i) begin
      valid_o <= valid_i;
      if (valid_i) begin
        x_o   <= x_r;
        y_o   <= y_r;
        z_o   <= z_d;
        neg_o <= neg_i;
        ovf_o <= ovf_i;
        tag_o <= tag_i;
      end
    end
  end

endmodule

// File: rtl/cordic_ppl_param.sv
// Pipelined CORDIC rotator: cos/sin of a fixed-point angle over [-pi, pi].
// Input range-reduction register, then NSTAGE rotation stages; the last one also negates.
module cordic_ppl_param
  import cordic_ppl_param_pkg::*;
#(
  parameter int unsigned WL             = 22,
  parameter int unsigned FRAC           = 19,
  parameter int unsigned N_ITER         = 16,
  parameter int unsigned ITER_PER_STAGE = 8,
  parameter int unsigned TAG_W          = 4
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 clk_en,
  input  logic                 in_valid,
  input  logic signed [WL-1:0] in_angle,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  output logic signed [WL-1:0] out_cos,
  output logic signed [WL-1:0] out_sin,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_ovf
);

  localparam int unsigned NSTAGE = N_ITER / ITER_PER_STAGE;

  function automatic logic [WL-1:0] q_const(input logic [63:0] v);
    logic [63:0] full;
    full = cordic_q(v, FRAC);
    return full[WL-1:0];
  endfunction

  localparam logic signed [WL-1:0] PI   = q_const(PI_Q32);
  localparam logic signed [WL-1:0] PI_2 = q_const(PI_2_Q32);
  localparam logic signed [WL-1:0] K    = q_const(K_Q32);

  if (ITER_PER_STAGE == 0 || N_ITER == 0 || (N_ITER % ITER_PER_STAGE) != 0) begin : g_bad_div
    $error("N_ITER must be a non-zero multiple of ITER_PER_STAGE");
  end
  if (N_ITER > FRAC || N_ITER > 32) begin : g_bad_iter
    $error("N_ITER must not exceed FRAC or 32");
  end
  if (WL < FRAC + 3) begin : g_bad_wl
    $error("WL-FRAC must be at least 3 so that +-pi fits");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("TAG_W must be at least 1");
  end

  logic signed [WL-1:0] a_sat, z_in;
  logic                 neg_in, ovf_in;

  // Clamp to [-pi, pi], then fold |a| > pi/2 into the right half-plane and remember to negate
  always_comb begin
    a_sat  = in_angle;
    ovf_in = 1'b0;
    if (in_angle > PI) begin
      a_sat  = PI;
      ovf_in = 1'b1;
    end else if (in_angle < -PI) begin
      a_sat  = -PI;
      ovf_in = 1'b1;
    end
    z_in   = a_sat;
    neg_in = 1'b0;
    if (a_sat > PI_2) begin
      z_in   = a_sat - PI;
      neg_in = 1'b1;
    end else if (a_sat < -PI_2) begin
      z_in   = a_sat + PI;
      neg_in = 1'b1;
    end
  end

  logic                 valid_c [NSTAGE+1];
  logic signed [WL-1:0] x_c     [NSTAGE+1];
  logic signed [WL-1:0] y_c     [NSTAGE+1];
  logic signed [WL-1:0] z_c     [NSTAGE+1];
  logic                 neg_c   [NSTAGE+1];
  logic                 ovf_c   [NSTAGE+1];
  logic [TAG_W-1:0]     tag_c   [NSTAGE+1];

  logic                 valid0_q, neg0_q, ovf0_q;
  logic signed [WL-1:0] z0_q;
  logic [TAG_W-1:0]     tag0_q;

  // Input register; x always starts at K and y at 0, so only z and the flags are stored
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      valid0_q <= 1'b0;
      z0_q     <= '0;
      neg0_q   <= 1'b0;
      ovf0_q   <= 1'b0;
      tag0_q   <= '0;
    end else if (clk_en) begin
      valid0_q <= in_valid;
      if (in_valid) begin
        z0_q   <= z_in;
        neg0_q <= neg_in;
        ovf0_q <= ovf_in;
        tag0_q <= in_tag;
      end
    end
  end

  // Reset leaves x at 0 too, matching an all-zero register file
  logic valid_seen_q;
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      valid_seen_q <= 1'b0;
    end else if (clk_en && in_valid) begin
      valid_seen_q <= 1'b1;
    end
  end

  assign valid_c[0] = valid0_q;
  assign x_c[0]     = valid_seen_q ? K : '0;
  assign y_c[0]     = '0;
  assign z_c[0]     = z0_q;
  assign neg_c[0]   = neg0_q;
  assign ovf_c[0]   = ovf0_q;
  assign tag_c[0]   = tag0_q;

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    cordic_ppl_param_stage #(
      .WL        (WL),
      .FRAC      (FRAC),
      .FIRST_ITER(s * ITER_PER_STAGE),
      .COUNT     (ITER_PER_STAGE),
      .TAG_W     (TAG_W),
      .NEG_OUT   (s == NSTAGE - 1)
    ) u_stage (
      .clock   (clock),
      .aclr_n  (aclr_n),
      .clk_en_i(clk_en),
      .valid_i (valid_c[s]),
      .x_i     (x_c[s]),
      .y_i     (y_c[s]),
      .z_i     (z_c[s]),
      .neg_i   (neg_c[s]),
      .ovf_i   (ovf_c[s]),
      .tag_i   (tag_c[s]),
      .valid_o (valid_c[s+1]),
      .x_o     (x_c[s+1]),
      .y_o     (y_c[s+1]),
      .z_o     (z_c[s+1]),
      .neg_o   (neg_c[s+1]),
      .ovf_o   (ovf_c[s+1]),
      .tag_o   (tag_c[s+1])
    );
  end

  assign out_valid = valid_c[NSTAGE];
  assign out_cos   = x_c[NSTAGE];
  assign out_sin   = y_c[NSTAGE];
  assign out_tag   = tag_c[NSTAGE];
  assign out_ovf   = ovf_c[NSTAGE];

endmodule

// File: tb/tb_cordic_ppl_param.sv
// Directed bench for cordic_ppl_param: default build plus a WL=24/FRAC=20/N_ITER=20/IPS=4 build.
module tb_cordic_ppl_param;

  localparam int PI19   = 1647099;
  localparam int PI2_19 = 823550;
  localparam int ONE19  = 524288;
  localparam int TOL    = 48;

  logic        clock = 1'b0;
  logic        aclr_n, clk_en;
  logic        in_valid;
  logic signed [21:0] in_angle;
  logic [3:0]  in_tag;
  logic        out_valid, out_ovf;
  logic signed [21:0] out_cos, out_sin;
  logic [3:0]  out_tag;

  logic        in_valid2;
  logic signed [23:0] in_angle2;
  logic [3:0]  in_tag2;
  logic        out_valid2, out_ovf2;
  logic signed [23:0] out_cos2, out_sin2;
  logic [3:0]  out_tag2;

  int errors = 0;
  int checks = 0;

  initial forever #5 clock = ~clock;

  cordic_ppl_param u_dut (
    .clock    (clock),
    .aclr_n   (aclr_n),
    .clk_en   (clk_en),
    .in_valid (in_valid),
    .in_angle (in_angle),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_cos  (out_cos),
    .out_sin  (out_sin),
    .out_tag  (out_tag),
    .out_ovf  (out_ovf)
  );

  cordic_ppl_param #(
    .WL(24), .FRAC(20), .N_ITER(20), .ITER_PER_STAGE(4), .TAG_W(4)
  ) u_dut2 (
    .clock    (clock),
    .aclr_n   (aclr_n),
    .clk_en   (clk_en),
    .in_valid (in_valid2),
    .in_angle (in_angle2),
    .in_tag   (in_tag2),
    .out_valid(out_valid2),
    .out_cos  (out_cos2),
    .out_sin  (out_sin2),
    .out_tag  (out_tag2),
    .out_ovf  (out_ovf2)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input longint obs, input longint exp, input longint tol);
    logic ok;
    checks++;
    ok = (obs >= exp - tol) && (obs <= exp + tol);
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int a, input int t);
    in_valid = 1'b1;
    in_angle = a[21:0];
    in_tag   = t[3:0];
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic chk_res(input string name, input int c, input int s, input int t, input int o);
    chk({name, ".valid"}, longint'(out_valid), 1);
    chk_tol({name, ".cos"}, longint'(out_cos), c, TOL);
    chk_tol({name, ".sin"}, longint'(out_sin), s, TOL);
    chk({name, ".tag"}, longint'(out_tag), t);
    chk({name, ".ovf"}, longint'(out_ovf), o);
  endtask

  initial begin
    aclr_n    = 1'b0;
    clk_en    = 1'b1;
    in_valid  = 1'b0;
    in_angle  = '0;
    in_tag    = '0;
    in_valid2 = 1'b0;
    in_angle2 = '0;
    in_tag2   = '0;

    // Reset state
    #12;
    chk("rst.valid", longint'(out_valid), 0);
    chk("rst.cos", longint'(out_cos), 0);
    chk("rst.sin", longint'(out_sin), 0);
    chk("rst.tag", longint'(out_tag), 0);
    chk("rst.ovf", longint'(out_ovf), 0);
    chk("rst.valid2", longint'(out_valid2), 0);
    #1 aclr_n = 1'b1;

    // 1. a = 0, latency 3
    step();
    drive(0, 3);
    step();
    idle();
    step();
    chk("lat.early", longint'(out_valid), 0);
    step();
    chk_res("zero", ONE19, 0, 3, 0);

    // 2. Back-to-back quadrants, including exact -pi/2
    step();
    drive(274517, 1);
    step();
    drive(1098066, 2);
    step();
    drive(-1235324, 3);
    step();
    chk_res("pi6", 454047, 262144, 1, 0);
    drive(-PI2_19, 4);
    step();
    chk_res("2pi3", -262144, 454047, 2, 0);
    idle();
    step();
    chk_res("m3pi4", -370727, -370727, 3, 0);
    step();
    chk_res("mpi2", 0, -ONE19, 4, 0);
    step();
    chk("b2b.bubble", longint'(out_valid), 0);
    chk_tol("b2b.hold_sin", longint'(out_sin), -ONE19, TOL);

    // 3. v, bubble, v with a two-cycle freeze
    drive(274517, 5);
    step();
    idle();
    step();
    drive(1098066, 6);
    clk_en = 1'b0;
    step();
    chk("stall.f1", longint'(out_valid), 0);
    step();
    chk("stall.f2", longint'(out_valid), 0);
    clk_en = 1'b1;
    step();
    chk_res("stall.v1", 454047, 262144, 5, 0);
    idle();
    step();
    chk("stall.bubble", longint'(out_valid), 0);
    chk_tol("stall.hold_cos", longint'(out_cos), 454047, TOL);
    chk("stall.hold_tag", longint'(out_tag), 5);
    step();
    chk_res("stall.v2", -262144, 454047, 6, 0);
    step();
    chk("stall.nodup", longint'(out_valid), 0);

    // 4. Out-of-range clamps, and exactly +pi which is in range
    drive(32'h1E0000, 7);
    step();
    drive(-32'sh1E0000, 8);
    step();
    drive(PI19, 9);
    step();
    chk_res("clamp.pos", -ONE19, 0, 7, 1);
    idle();
    step();
    chk_res("clamp.neg", -ONE19, 0, 8, 1);
    step();
    chk_res("pi.exact", -ONE19, 0, 9, 0);

    // 5. Asynchronous reset with two operations in flight
    drive(274517, 1);
    step();
    drive(1098066, 2);
    step();
    #2 aclr_n = 1'b0;
    #1;
    chk("arst.valid", longint'(out_valid), 0);
    chk("arst.cos", longint'(out_cos), 0);
    chk("arst.sin", longint'(out_sin), 0);
    chk("arst.tag", longint'(out_tag), 0);
    chk("arst.ovf", longint'(out_ovf), 0);
    idle();
    #2 aclr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arst.nostale", longint'(out_valid), 0);
    end
    drive(0, 10);
    step();
    idle();
    step();
    step();
    chk_res("arst.next", ONE19, 0, 10, 0);

    // 6. Wide build: latency 6, a = pi/3 at FRAC=20
    in_valid2 = 1'b1;
    in_angle2 = 24'sd1098066;
    in_tag2   = 4'd9;
    step();
    in_valid2 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("w.lat.early", longint'(out_valid2), 0);
    step();
    chk("w.valid", longint'(out_valid2), 1);
    chk_tol("w.cos", longint'(out_cos2), 524288, 16);
    chk_tol("w.sin", longint'(out_sin2), 908093, 16);
    chk("w.tag", longint'(out_tag2), 9);
    chk("w.ovf", longint'(out_ovf2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
